// File: rtl/ps2_key_tracker_if.sv
// Key-tracker bus: scan-code byte stream in, frame tick, paced move handshake out, status.
interface ps2_key_tracker_if;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic       frame_tick;
  logic       move_ready;
  logic [2:0] move;
  logic       move_valid;
  logic [4:0] held;
  logic       overrun;

  modport master (
    input  rx_data, rx_done_tick, frame_tick, move_ready,
    output move, move_valid, held, overrun
  );

  modport slave (
    output rx_data, rx_done_tick, frame_tick, move_ready,
    input  move, move_valid, held, overrun
  );
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 decoder into a held-key bitmap; emits one prioritised move per frame tick.
// Latency: held 1 cycle after the final byte, move 1 cycle after frame_tick. Macro: PS2_KEY_TRACKER_ARROW_KEYS_EN.
module ps2_key_tracker #(
  parameter bit TAP_CAPTURE = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  ps2_key_tracker_if.master     bus
);

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

  state_t     state, state_nxt;
  logic [4:0] held_q, tap_q;
  logic [4:0] set_mask, clr_mask, std_mask, ext_mask, cand;
  logic [2:0] move_q;
  logic       move_valid_q, overrun_q, load, accept;

  function automatic logic [4:0] map_std(input logic [7:0] code);
    case (code)
      8'h1D:   map_std = 5'b00001;
      8'h1B:   map_std = 5'b00010;
      8'h1C:   map_std = 5'b00100;
      8'h23:   map_std = 5'b01000;
      8'h29:   map_std = 5'b10000;
      default: map_std = 5'b00000;
    endcase
  endfunction

`ifdef PS2_KEY_TRACKER_ARROW_KEYS_EN
  function automatic logic [4:0] map_ext(input logic [7:0] code);
    case (code)
      8'h75:   map_ext = 5'b00001;
      8'h72:   map_ext = 5'b00010;
      8'h6B:   map_ext = 5'b00100;
      8'h74:   map_ext = 5'b01000;
      default: map_ext = 5'b00000;
    endcase
  endfunction
`endif

  // Lowest set bit wins: up > down > left > right > action.
  function automatic logic [2:0] prio(input logic [4:0] c);
    prio = 3'd0;
    for (int i = 4; i >= 0; i--)
      if (c[i]) prio = 3'(i + 1);
  endfunction

  always_comb begin
    std_mask = map_std(bus.rx_data);
`ifdef PS2_KEY_TRACKER_ARROW_KEYS_EN
    ext_mask = map_ext(bus.rx_data);
`else
    ext_mask = 5'b00000;
`endif
    set_mask  = 5'b00000;
    clr_mask  = 5'b00000;
    state_nxt = state;
    if (bus.rx_done_tick) begin
      case (state)
        S_IDLE: begin
          if (bus.rx_data == 8'hF0)      state_nxt = S_BRK;
          else if (bus.rx_data == 8'hE0) state_nxt = S_EXT;
          else                           set_mask  = std_mask;
        end
        S_BRK: begin
          clr_mask  = std_mask;
          state_nxt = S_IDLE;
        end
        S_EXT: begin
          if (bus.rx_data == 8'hF0) state_nxt = S_EXT_BRK;
          else begin
            set_mask  = ext_mask;
            state_nxt = S_IDLE;
          end
        end
        default: begin
          clr_mask  = ext_mask;
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign cand   = held_q | (TAP_CAPTURE ? tap_q : 5'b00000);
  assign load   = bus.frame_tick && (cand != 5'b00000);
  assign accept = move_valid_q && bus.move_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      held_q       <= 5'b00000;
      tap_q        <= 5'b00000;
      move_q       <= 3'd0;
      move_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      held_q <= (held_q | set_mask) & ~clr_mask;
      // A tap made in the tick cycle was not sampled, so it must outlive the clear.
      tap_q  <= (load ? 5'b00000 : tap_q) | set_mask;
      if (load) begin
        move_q       <= prio(cand);
        move_valid_q <= 1'b1;
        if (move_valid_q && !bus.move_ready) overrun_q <= 1'b1;
      end else if (accept) begin
        move_q       <= 3'd0;
        move_valid_q <= 1'b0;
      end
    end
  end

  assign bus.held       = held_q;
  assign bus.move       = move_q;
  assign bus.move_valid = move_valid_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed plan plus random byte/tick/ready traffic against a sequence-level key model, both TAP_CAPTURE settings.
module tb_ps2_key_tracker;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done_tick = 1'b0;
  logic       frame_tick = 1'b0;
  logic       move_ready = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  ps2_key_tracker_if if1 ();
  ps2_key_tracker_if if0 ();

  assign if1.rx_data = rx_data;   assign if0.rx_data = rx_data;
  assign if1.rx_done_tick = rx_done_tick; assign if0.rx_done_tick = rx_done_tick;
  assign if1.frame_tick = frame_tick;     assign if0.frame_tick = frame_tick;
  assign if1.move_ready = move_ready;     assign if0.move_ready = move_ready;

  ps2_key_tracker #(.TAP_CAPTURE(1'b1)) dut1 (.clk(clk), .resetn(resetn), .bus(if1));
  ps2_key_tracker #(.TAP_CAPTURE(1'b0)) dut0 (.clk(clk), .resetn(resetn), .bus(if0));

  always #5 clk = ~clk;

  // Reference model: bytes of the current scan-code sequence, held keys, per-variant tap/move state.
  logic [7:0] seq[$];
  logic [4:0] m_held;
  logic [4:0] m_tap[2];
  logic [2:0] m_mo[2];
  logic       m_mv[2];
  logic       m_ov[2];

  function automatic int key_of(input bit ext, input logic [7:0] c);
    if (!ext) begin
      case (c)
        8'h1D: return 0;
        8'h1B: return 1;
        8'h1C: return 2;
        8'h23: return 3;
        8'h29: return 4;
        default: return -1;
      endcase
    end
`ifdef PS2_KEY_TRACKER_ARROW_KEYS_EN
    case (c)
      8'h75: return 0;
      8'h72: return 1;
      8'h6B: return 2;
      8'h74: return 3;
      default: return -1;
    endcase
`else
    return -1;
`endif
  endfunction

  task automatic m_byte(input logic [7:0] b);
    bit incomplete, ext, brk;
    int k;
    seq.push_back(b);
    incomplete = (seq.size() == 1 && (b == 8'hF0 || b == 8'hE0)) ||
                 (seq.size() == 2 && seq[0] == 8'hE0 && b == 8'hF0);
    if (!incomplete) begin
      ext = (seq.size() > 1) && (seq[0] == 8'hE0);
      brk = (seq.size() >= 2) && (seq[seq.size()-2] == 8'hF0);
      k = key_of(ext, b);
      if (k >= 0) begin
        if (brk) m_held[k] = 1'b0;
        else begin
          m_held[k] = 1'b1;
          m_tap[0][k] = 1'b1;
          m_tap[1][k] = 1'b1;
        end
      end
      seq.delete();
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("held_t1", {3'b0, if1.held}, {3'b0, m_held});
    chk("held_t0", {3'b0, if0.held}, {3'b0, m_held});
    chk("move_t1", {5'b0, if1.move}, {5'b0, m_mo[1]});
    chk("move_t0", {5'b0, if0.move}, {5'b0, m_mo[0]});
    chk("valid_t1", {7'b0, if1.move_valid}, {7'b0, m_mv[1]});
    chk("valid_t0", {7'b0, if0.move_valid}, {7'b0, m_mv[0]});
    chk("ovr_t1", {7'b0, if1.overrun}, {7'b0, m_ov[1]});
    chk("ovr_t0", {7'b0, if0.overrun}, {7'b0, m_ov[0]});
  endtask

  task automatic step(input bit bv, input logic [7:0] b, input bit tk, input bit rdy);
    logic [4:0] cand;
    bit acc;
    rx_data = b; rx_done_tick = bv; frame_tick = tk; move_ready = rdy;
    @(posedge clk);
    for (int v = 0; v < 2; v++) begin
      acc  = m_mv[v] && rdy;
      cand = m_held | (v == 1 ? m_tap[v] : 5'b0);
      if (tk && cand != 5'b0) begin
        if (m_mv[v] && !acc) m_ov[v] = 1'b1;
        m_mv[v] = 1'b1;
        m_tap[v] = 5'b0;
        for (int i = 4; i >= 0; i--) if (cand[i]) m_mo[v] = 3'(i + 1);
      end else if (acc) begin
        m_mv[v] = 1'b0;
        m_mo[v] = 3'd0;
      end
    end
    if (bv) m_byte(b);
    #1;
    rx_done_tick = 1'b0; frame_tick = 1'b0; move_ready = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #2;
    seq.delete();
    m_held = 5'b0;
    for (int v = 0; v < 2; v++) begin
      m_tap[v] = 5'b0; m_mo[v] = 3'd0; m_mv[v] = 1'b0; m_ov[v] = 1'b0;
    end
    check_all();
    #2 resetn = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic tick(input bit rdy);
    step(1'b0, 8'h00, 1'b1, rdy);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 8'h00, 1'b0, rdy);
  endtask

  logic [7:0] pool [12] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'hF0,
                             8'hE0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A};

  initial begin
    do_reset();

    // Hold W, then accept.
    send(8'h1D); tick(1'b0);
    chk("w_held", {3'b0, if1.held}, 8'h01);
    chk("w_move", {5'b0, if1.move}, 8'h01);
    chk("w_valid", {7'b0, if1.move_valid}, 8'h01);
    idle(1'b1);
    chk("w_acc_valid", {7'b0, if1.move_valid}, 8'h00);
    chk("w_acc_move", {5'b0, if1.move}, 8'h00);
    send(8'hF0); send(8'h1D);

    // A and D held: left beats right, then release A.
    send(8'h1C); send(8'h23); tick(1'b0);
    chk("ad_held", {3'b0, if1.held}, 8'h0C);
    chk("ad_move", {5'b0, if1.move}, 8'h03);
    idle(1'b1);
    send(8'hF0); send(8'h1C); tick(1'b0);
    chk("d_move", {5'b0, if1.move}, 8'h04);
    idle(1'b1);
    send(8'hF0); send(8'h23);

    // Space tapped between ticks.
    send(8'h29); send(8'hF0); send(8'h29); tick(1'b0);
    chk("tap_move", {5'b0, if1.move}, 8'h05);
    chk("tap_held", {3'b0, if1.held}, 8'h00);
    chk("tap0_valid", {7'b0, if0.move_valid}, 8'h00);
    idle(1'b1); tick(1'b0);
    chk("tap_again", {7'b0, if1.move_valid}, 8'h00);

    // Extended down arrow.
    send(8'hE0); send(8'h72); tick(1'b0);
`ifdef PS2_KEY_TRACKER_ARROW_KEYS_EN
    chk("ext_move", {5'b0, if1.move}, 8'h02);
`else
    chk("ext_held", {3'b0, if1.held}, 8'h00);
    chk("ext_valid", {7'b0, if1.move_valid}, 8'h00);
`endif
    idle(1'b1);
    send(8'hE0); send(8'hF0); send(8'h72);
    chk("ext_brk", {7'b0, if1.held[1]}, 8'h00);

    // Overrun on an unaccepted move, cleared only by reset.
    send(8'h1B); tick(1'b0); tick(1'b0);
    chk("ovr_flag", {7'b0, if1.overrun}, 8'h01);
    chk("ovr_move", {5'b0, if1.move}, 8'h02);
    do_reset();

    // Reset in the middle of a break sequence.
    send(8'hF0); do_reset(); send(8'h1D);
    chk("midrst_held", {3'b0, if1.held}, 8'h01);

    // Acceptance together with a loading tick: no overrun.
    tick(1'b0); step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("acc_tick_valid", {7'b0, if1.move_valid}, 8'h01);
    chk("acc_tick_ovr", {7'b0, if1.overrun}, 8'h00);
    do_reset();

    // Byte in the tick cycle is not sampled, its tap counts next tick.
    step(1'b1, 8'h29, 1'b1, 1'b0);
    chk("same_cyc_valid", {7'b0, if1.move_valid}, 8'h00);
    send(8'hF0); send(8'h29); tick(1'b0);
    chk("same_cyc_next", {5'b0, if1.move}, 8'h05);
    do_reset();

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else step($urandom_range(0, 2) == 0, pool[$urandom_range(0, 11)],
                $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Tracks which game keys are held and turns them into frame-paced moves. It consumes the byte stream from `ps2_rx` (`rx_data`, `rx_done_tick`) and decodes PS/2 set-2 make, break (`F0`) and extended (`E0`) sequences into a held-key bitmap. Once per frame tick it presents one prioritised 3-bit move code to the position-update / `collision_detector` stage over a valid/ready handshake. Short taps that start and end between two frame ticks are still delivered.

## Interface
- `TAP_CAPTURE`, default 1: 1 = a key pressed and released between frame ticks still yields one move; 0 = only keys held at the tick count.
- `clk` input 1: system clock (CLOCK_50).
- `resetn` input 1: asynchronous, active-low reset.
- `rx_data` input 8: received scan-code byte; valid only while `rx_done_tick`=1.
- `rx_done_tick` input 1: one-cycle strobe per received byte.
- `frame_tick` input 1: one-cycle strobe at 60 Hz from the frame divider.
- `move_ready` input 1: consumer accepts `move` when high together with `move_valid`.
- `move` output 3: 000 none, 001 up, 010 down, 011 left, 100 right, 101 action.
- `move_valid` output 1: `move` is pending.
- `held` output 5: held bitmap {action,right,left,down,up}.
- `overrun` output 1: sticky; a pending move was overwritten before acceptance.

## Operation
- Key map, set 2: up = `1D` (W); down = `1B` (S); left = `1C` (A); right = `23` (D); action = `29` (space).
- With `ARROW_KEYS_EN`: additionally `E0 75` up, `E0 72` down, `E0 6B` left, `E0 74` right.
- Decoder FSM, advanced only on `rx_done_tick`: IDLE, BRK, EXT, EXT_BRK.
- IDLE: byte `F0` -> BRK; `E0` -> EXT; a mapped code sets its `held` bit and its `tap` bit; any other byte is ignored and the FSM stays in IDLE.
- BRK: a mapped code clears its `held` bit; any byte -> IDLE.
- EXT: `F0` -> EXT_BRK; a mapped extended code sets `held`/`tap`; any other byte -> IDLE.
- EXT_BRK: a mapped extended code clears `held`; any byte -> IDLE.
- Typematic repeats (repeated make codes) re-set bits that are already set, so they are harmless.
- On `frame_tick`, the candidate set = `held` | (`TAP_CAPTURE` ? `tap` : 0). Fixed priority: up > down > left > right > action.
- On `frame_tick` with a non-empty candidate set: load `move`, set `move_valid`, clear all `tap` bits.
- On `frame_tick` with an empty candidate set: no change, so an already pending move is kept.
- If `move_valid`=1 and not accepted in that cycle when a tick loads a new move: overwrite `move` and set `overrun`. `overrun` clears only on reset.
- Acceptance (`move_valid` & `move_ready`): clear `move_valid`; set `move` to 000.

## Timing
- Reset: FSM=IDLE; `held`, `tap`, `move`, `move_valid`, `overrun` are all 0.
- `held` updates on the clock edge after the final byte of a sequence, which is 1-cycle latency from `rx_done_tick`.
- `move`/`move_valid` update on the edge after `frame_tick`.
- A byte and `frame_tick` in the same cycle: the tick samples the pre-update `held`/`tap`. A `tap` bit set by that byte survives the clearing and counts at the next tick.
- Acceptance and a loading tick in the same cycle: the new move loads, `move_valid` stays 1, and `overrun` is not set.
- `move_ready` with `move_valid`=0 has no effect.
- `resetn` low mid-sequence, for example after `E0`, returns the FSM to IDLE. The next byte is then decoded as a fresh sequence.

## Configuration
- `PS2_KEY_TRACKER_ARROW_KEYS_EN` defined: extended arrow codes are mapped as listed above.
- Not defined: EXT and EXT_BRK still consume the byte following `E0`, but nothing is mapped. Arrow keys therefore never affect `held`, and their `E0 F0 xx` break sequences leave WASD state untouched.

## Test plan
- Press and hold W: send `1D`, then a `frame_tick` with `move_ready`=0. Require `held`=00001, `move`=001, `move_valid`=1. Raise `move_ready` for one cycle: `move_valid`=0, `move`=000.
- Press A then D, with no break codes, then a tick. Require `held`=01100 and `move`=011 (left beats right). Send `F0 1C`, then a tick. Require `move`=100.
- Tap, with `TAP_CAPTURE`=1: send `29 F0 29` between ticks. The next tick gives `move`=101 and `held`=00000; the following tick gives no new move. With `TAP_CAPTURE`=0 there is no move.
- Extended keys: send `E0 72` then a tick. With the macro defined, require `move`=010; without it, `held`=00000 and `move_valid` stays 0. Then send `E0 F0 72` and check that `held` bit1 clears (macro defined).
- Overrun: hold S (`1B`), give two ticks with `move_ready`=0. Require `overrun`=1 and `move`=010. Apply reset: all outputs 0.
- Reset mid-sequence: send `F0`, pulse `resetn` low, then send `1D`. Require `held`=00001, meaning the byte is decoded as a make code and not a break.
